// File: rtl/updown_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : updown_pkg
//  Description : Shared types for the up/down guessing game: FSM state
//                encoding, default widths and the verdict encoding that is
//                also consumed by the display/LED driver.
//  Revision    : 1.0 - initial release
// ============================================================================
package updown_pkg;

   localparam int NUM_W_DEF     = 7;
   localparam int RANGE_MAX_DEF = 99;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PLAY  = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      VERDICT_UP      = 2'd0,
      VERDICT_DOWN    = 2'd1,
      VERDICT_CORRECT = 2'd2,
      VERDICT_INVALID = 2'd3
   } verdict_e;

   // One-hot flag vector {hint_up, hint_down, correct, invalid} for a verdict
   function automatic logic [3:0] verdict_flags(input verdict_e v);
      logic [3:0] f;
      f = 4'b0000;
      case (v)
         VERDICT_UP:      f = 4'b1000;
         VERDICT_DOWN:    f = 4'b0100;
         VERDICT_CORRECT: f = 4'b0010;
         default:         f = 4'b0001;
      endcase
      return f;
   endfunction

endpackage
`default_nettype wire

// File: rtl/guess_judge_if.sv
`default_nettype none
// ============================================================================
//  Module      : guess_judge_if
//  Description : Bundle of secret/guess handshake inputs and verdict outputs
//                of the guess judge. master = game front end, slave = judge.
//  Revision    : 1.0 - initial release
// ============================================================================
interface guess_judge_if #(
   parameter int NUM_W = updown_pkg::NUM_W_DEF
) ();

   logic             secret_valid;
   logic [NUM_W-1:0] secret_number;
   logic             guess_valid;
   logic [NUM_W-1:0] guess;
   logic             ready;
   logic             result_valid;
   logic             hint_up;
   logic             hint_down;
   logic             correct;
   logic             invalid;
   logic             game_over;
   logic             win;
   logic [3:0]       tries_used;

   modport master (
      output secret_valid, secret_number, guess_valid, guess,
      input  ready, result_valid, hint_up, hint_down, correct, invalid,
             game_over, win, tries_used
   );

   modport slave (
      input  secret_valid, secret_number, guess_valid, guess,
      output ready, result_valid, hint_up, hint_down, correct, invalid,
             game_over, win, tries_used
   );

endinterface
`default_nettype wire

// File: rtl/guess_compare.sv
`default_nettype none
// ============================================================================
//  Module      : guess_compare
//  Description : Combinational judge of one guess against the secret.
//                Out-of-range guesses are invalid regardless of the secret.
//  Revision    : 1.0 - initial release
// ============================================================================
module guess_compare
   import updown_pkg::*;
#(
   parameter int NUM_W     = NUM_W_DEF,
   parameter int RANGE_MAX = RANGE_MAX_DEF
) (
   input  wire logic [NUM_W-1:0] secret,
   input  wire logic [NUM_W-1:0] guess,
   output verdict_e              verdict
);

   localparam logic [NUM_W-1:0] C_RANGE_MAX = NUM_W'(RANGE_MAX);

   // Range check first, then unsigned magnitude compare
   always_comb begin
      verdict = VERDICT_INVALID;
      if (guess > C_RANGE_MAX)
         verdict = VERDICT_INVALID;
      else if (guess == secret)
         verdict = VERDICT_CORRECT;
      else if (secret > guess)
         verdict = VERDICT_UP;
      else
         verdict = VERDICT_DOWN;
   end

endmodule
`default_nettype wire

// File: rtl/guess_judge.sv
`default_nettype none
// ============================================================================
//  Module      : guess_judge
//  Description : Latches the secret from the number generator, accepts
//                guesses over valid/ready, answers up/down/correct/invalid,
//                counts attempts and ends the game on a win or exhaustion.
//  Revision    : 1.0 - initial release
// ============================================================================
module guess_judge
   import updown_pkg::*;
#(
   parameter int NUM_W     = NUM_W_DEF,
   parameter int RANGE_MAX = RANGE_MAX_DEF,
   parameter int MAX_TRIES = 7
) (
   input  wire logic     clk,
   input  wire logic     reset,
   guess_judge_if.slave  bus
);

   localparam logic [1:0]       C_IDLE       = 2'(ST_IDLE);
   localparam logic [1:0]       C_PLAY       = 2'(ST_PLAY);
   localparam logic [1:0]       C_CHECK      = 2'(ST_CHECK);
   localparam logic [1:0]       C_DONE       = 2'(ST_DONE);
   localparam logic [NUM_W-1:0] C_RANGE_MAX  = NUM_W'(RANGE_MAX);
   localparam logic [NUM_W-1:0] C_RANGE_SPAN = NUM_W'(RANGE_MAX + 1);
   localparam logic [3:0]       C_MAX_TRIES  = 4'(MAX_TRIES);

   logic [1:0]       r_state;
   logic [NUM_W-1:0] r_secret;
   logic [NUM_W-1:0] r_guess;
   logic [3:0]       r_tries;
   logic             r_result_valid;
   logic             r_hint_up;
   logic             r_hint_down;
   logic             r_correct;
   logic             r_invalid;
   logic             r_game_over;
   logic             r_win;

   verdict_e         w_verdict;
   logic [3:0]       w_flags;
   logic [NUM_W-1:0] w_secret_fold;
   logic [3:0]       w_tries_inc;

   // Raw generator values above the legal range are folded back into it
   assign w_secret_fold = (bus.secret_number <= C_RANGE_MAX)
                        ? bus.secret_number
                        : bus.secret_number - C_RANGE_SPAN;

   // Attempt counter increment, pinned at the limit so it can never wrap
   assign w_tries_inc = (r_tries >= C_MAX_TRIES) ? r_tries : r_tries + 4'd1;

   assign w_flags = verdict_flags(w_verdict);

   guess_compare #(
      .NUM_W     (NUM_W),
      .RANGE_MAX (RANGE_MAX)
   ) u_compare (
      .secret  (r_secret),
      .guess   (r_guess),
      .verdict (w_verdict)
   );

   // Game FSM: new-game latch has priority, CHECK registers the verdict
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= C_IDLE;
         r_secret       <= '0;
         r_guess        <= '0;
         r_tries        <= 4'd0;
         r_result_valid <= 1'b0;
         r_hint_up      <= 1'b0;
         r_hint_down    <= 1'b0;
         r_correct      <= 1'b0;
         r_invalid      <= 1'b0;
         r_game_over    <= 1'b0;
         r_win          <= 1'b0;
      end else begin
         r_result_valid <= 1'b0;
         if (bus.secret_valid) begin
            // Also aborts a pending CHECK and drops a same-cycle guess
            r_secret    <= w_secret_fold;
            r_tries     <= 4'd0;
            r_hint_up   <= 1'b0;
            r_hint_down <= 1'b0;
            r_correct   <= 1'b0;
            r_invalid   <= 1'b0;
            r_game_over <= 1'b0;
            r_win       <= 1'b0;
            r_state     <= C_PLAY;
         end else begin
            case (r_state)
               C_PLAY: begin
                  if (bus.guess_valid) begin
                     r_guess <= bus.guess;
                     r_state <= C_CHECK;
                  end
               end
               C_CHECK: begin
                  r_result_valid <= 1'b1;
                  {r_hint_up, r_hint_down, r_correct, r_invalid} <= w_flags;
                  if (w_verdict == VERDICT_INVALID) begin
                     r_state <= C_PLAY;
                  end else if (w_verdict == VERDICT_CORRECT) begin
                     // A hit on the final try still counts as a win
                     r_tries     <= w_tries_inc;
                     r_game_over <= 1'b1;
                     r_win       <= 1'b1;
                     r_state     <= C_DONE;
                  end else begin
                     r_tries <= w_tries_inc;
                     if (w_tries_inc == C_MAX_TRIES) begin
                        r_game_over <= 1'b1;
                        r_win       <= 1'b0;
                        r_state     <= C_DONE;
                     end else begin
                        r_state <= C_PLAY;
                     end
                  end
               end
               default: r_state <= r_state;
            endcase
         end
      end
   end

   assign bus.ready        = (r_state == C_PLAY);
   assign bus.result_valid = r_result_valid;
   assign bus.hint_up      = r_hint_up;
   assign bus.hint_down    = r_hint_down;
   assign bus.correct      = r_correct;
   assign bus.invalid      = r_invalid;
   assign bus.game_over    = r_game_over;
   assign bus.win          = r_win;
   assign bus.tries_used   = r_tries;

endmodule
`default_nettype wire
